// File: rtl/haar_cascade_scheduler.sv
// rtl/haar_cascade_scheduler.sv - Haar cascade stage sequencer with saturating leaf accumulator.
// Optional stall watchdog compiled in with HAAR_SCHED_WATCHDOG_EN.
module haar_cascade_scheduler #(
    parameter int NUM_STAGES      = 25,
    parameter int DATA_WIDTH_16   = 16,
    parameter int ACC_WIDTH       = 20,
    parameter int STAGE_IDX_WIDTH = 5,
    parameter int WDT_LIMIT       = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic                       i_tree_valid,
    input  logic [DATA_WIDTH_16-1:0]   i_tree_value,
    input  logic                       i_thr_valid,
    input  logic [DATA_WIDTH_16-1:0]   i_thr_value,
    output logic [NUM_STAGES-1:0]      o_stage_en,
    output logic [STAGE_IDX_WIDTH-1:0] o_stage_idx,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_face,
    output logic                       o_error
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_e;

    localparam logic [ACC_WIDTH-1:0]       ACC_MAX    = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]       ACC_MIN    = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [STAGE_IDX_WIDTH-1:0] LAST_STAGE = STAGE_IDX_WIDTH'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0]      EN_ONE     = NUM_STAGES'(1);

    state_e                       state_q, state_d;
    logic [STAGE_IDX_WIDTH-1:0]   stage_q, stage_d;
    logic [ACC_WIDTH-1:0]         acc_q, acc_d;
    logic [DATA_WIDTH_16-1:0]     thr_q, thr_d;
    logic                         face_q, face_d;
    logic [NUM_STAGES-1:0]        stage_en_q, stage_en_d;
    logic                         busy_q, done_q;

    logic [ACC_WIDTH:0]           sum;
    logic [ACC_WIDTH-1:0]         acc_add;
    logic [ACC_WIDTH-1:0]         thr_ext;
    logic                         pass;

`ifdef HAAR_SCHED_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_LIMIT + 1);
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             error_q, error_d;
`endif

    // One guard bit above the accumulator exposes overflow for saturation.
    always_comb begin
        sum     = {acc_q[ACC_WIDTH-1], acc_q} + (ACC_WIDTH+1)'($signed(i_tree_value));
        acc_add = sum[ACC_WIDTH-1:0];
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            acc_add = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        thr_ext = ACC_WIDTH'($signed(thr_q));
        pass    = $signed(acc_q) >= $signed(thr_ext);
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        acc_d   = acc_q;
        thr_d   = thr_q;
        face_d  = face_q;
`ifdef HAAR_SCHED_WATCHDOG_EN
        error_d = error_q;
        wdt_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    stage_d = '0;
                    acc_d   = '0;
                    face_d  = 1'b0;
`ifdef HAAR_SCHED_WATCHDOG_EN
                    error_d = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (i_tree_valid) begin
                    acc_d = acc_add;
                end
                if (i_thr_valid) begin
                    thr_d   = i_thr_value;
                    state_d = S_CHECK;
                end
`ifdef HAAR_SCHED_WATCHDOG_EN
                else if (!i_tree_valid) begin
                    if (wdt_q == WDT_W'(WDT_LIMIT)) begin
                        state_d = S_DONE;
                        face_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        wdt_d = wdt_q + 1'b1;
                    end
                end
`endif
            end
            S_CHECK: begin
                if (pass && stage_q != LAST_STAGE) begin
                    stage_d = stage_q + 1'b1;
                    acc_d   = '0;
                    state_d = S_RUN;
                end else begin
                    face_d  = pass;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (i_abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            stage_d = stage_q;
            acc_d   = '0;
            face_d  = face_q;
`ifdef HAAR_SCHED_WATCHDOG_EN
            error_d = error_q;
`endif
        end

        // Enables follow the next state so CHECK drops them for a full cycle.
        stage_en_d = (state_d == S_RUN) ? (EN_ONE << stage_d) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            stage_q    <= '0;
            acc_q      <= '0;
            thr_q      <= '0;
            face_q     <= 1'b0;
            stage_en_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            acc_q      <= acc_d;
            thr_q      <= thr_d;
            face_q     <= face_d;
            stage_en_q <= stage_en_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

`ifdef HAAR_SCHED_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            wdt_q   <= wdt_d;
            error_q <= error_d;
        end
    end
    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

    assign o_stage_en  = stage_en_q;
    assign o_stage_idx = stage_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_face      = face_q;
endmodule

// File: doc/haar_cascade_scheduler.md
# haar_cascade_scheduler

Sequences the Haar cascade over one candidate window. It enables one stage database at a time, accumulates per-tree leaf values returned by the feature evaluator, and compares the sum against the stage threshold. The window is rejected early on the first failing stage, or accepted after the last stage passes. The block sits between the window-ready logic and the per-stage database bank plus evaluator.

## Interface
- NUM_STAGES, 25, number of cascade stages / database instances
- DATA_WIDTH_16, 16, width of signed leaf values and stage thresholds
- ACC_WIDTH, 20, signed stage accumulator width (≥ DATA_WIDTH_16)
- STAGE_IDX_WIDTH, 5, width of stage index (≥ clog2(NUM_STAGES))
- WDT_LIMIT, 1023, watchdog idle-cycle limit (used only with watchdog compiled in)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- i_start  in  1  window ready; sampled in IDLE only
- i_abort  in  1  cancel current window; no o_done
- i_tree_valid  in  1  leaf value of one tree valid this cycle
- i_tree_value  in  DATA_WIDTH_16  signed leaf value
- i_thr_valid  in  1  stage threshold valid; marks end of current stage
- i_thr_value  in  DATA_WIDTH_16  signed stage threshold
- o_stage_en  out  NUM_STAGES  one-hot enable to stage databases (low = database held in reset)
- o_stage_idx  out  STAGE_IDX_WIDTH  current stage index
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle result strobe
- o_face  out  1  result: 1 = all stages passed; valid with o_done, held until next i_start
- o_error  out  1  watchdog fired; valid with o_done

## Operation
- States: IDLE, RUN, CHECK, DONE.
- IDLE: o_stage_en=0. i_start=1 → RUN, stage=0, acc=0, o_face=0, o_error=0.
- RUN: o_stage_en = 1<<stage.
  - Each i_tree_valid: acc += sign-extended i_tree_value.
  - Accumulation saturates at ±(2^(ACC_WIDTH-1)) limits (max = 2^(ACC_WIDTH-1)-1, min = -2^(ACC_WIDTH-1)); no wrap.
  - i_thr_valid: latch threshold → CHECK.
  - If i_tree_valid and i_thr_valid occur in the same cycle, the tree value is added before the compare.
- CHECK: o_stage_en=0 for exactly one cycle, so every database resets. Compare acc ≥ sign-extended threshold (signed).
  - Pass and stage<NUM_STAGES-1 → stage+1, acc=0, RUN.
  - Pass on the last stage → DONE, o_face=1.
  - Fail → DONE, o_face=0.
- DONE: o_done=1 for one cycle; o_stage_idx holds the deciding stage; → IDLE.
- i_abort (any non-IDLE state, highest priority) → IDLE next cycle. acc cleared, o_stage_en=0, no o_done, o_face unchanged.
- i_start while o_busy is ignored.
- i_tree_valid/i_thr_valid outside RUN are ignored.

## Timing
- Reset: state IDLE. o_stage_en=0, o_stage_idx=0, o_busy=0, o_done=0, o_face=0, o_error=0, acc=0.
- All outputs registered.
- i_start at edge t → RUN; o_stage_en[0]=1 and o_busy=1 from cycle t+1.
- i_thr_valid at edge t → CHECK in cycle t+1 (enables low). Cycle t+2 is either RUN with the next enable, or DONE with o_done=1.
- Minimum per-stage overhead: 1 cycle (CHECK). Latency from final i_thr_valid to o_done is 2 cycles.
- Reset asserted mid-window: immediate return to reset values; no o_done.

## Configuration
- HAAR_SCHED_WATCHDOG_EN defined: a cycle counter runs in RUN, cleared on each i_tree_valid, i_thr_valid and stage entry.
  - On reaching WDT_LIMIT consecutive idle cycles → DONE with o_face=0, o_error=1.
- HAAR_SCHED_WATCHDOG_EN undefined: no counter is present, o_error is tied 0, and RUN waits indefinitely.

## Test plan
- NUM_STAGES=3, all stages send leaf values {5,5} with threshold 10 → o_stage_en steps 001,000,010,000,100,000. o_done=1 with o_face=1 two cycles after the third i_thr_valid; o_stage_idx=2.
- Stage 0 passes; stage 1 sends leaves {-3,2} with threshold 0 → o_done with o_face=0 and o_stage_idx=1; stage 2 is never enabled.
- i_tree_valid(value 4) coincides with i_thr_valid(threshold 4) after a previous sum of 0 → the stage passes (acc=4 ≥ 4).
- ACC_WIDTH=17, 10 leaves of 0x7FFF → acc saturates at 65535 with no wrap. A threshold of -1 passes; a leaf of -32768 then yields 32767.
- i_abort during RUN at stage 1 → IDLE next cycle, o_stage_en=0, no o_done. A new i_start restarts at stage 0 with acc=0.
- With HAAR_SCHED_WATCHDOG_EN and WDT_LIMIT=8: no inputs after i_start → o_done=1, o_error=1, o_face=0 at cycle t+1+8+1. Without the macro, o_busy stays high and o_error=0.
